// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: encodings and helpers shared by the MEM stage.
//   MEMOP_*   : access size carried on MEMOp.
//   WBDATA_*  : write-back data source carried on mux_WBData.
//   MEMST_*   : MEM-stage FSM state encodings.
//   wb_bundle_t : contents of the MEM/WB register.
//   store_be / store_wdata : byte-lane enables and replicated store data.
//   is_misaligned : alignment check used when MISALIGN_TRAP_EN is defined.
package mem_stage_pkg;

  localparam logic [1:0] MEMOP_BYTE     = 2'd0;
  localparam logic [1:0] MEMOP_HALF     = 2'd1;
  localparam logic [1:0] MEMOP_WORD     = 2'd2;

  localparam logic [1:0] WBDATA_ALU     = 2'd0;
  localparam logic [1:0] WBDATA_MEM     = 2'd1;
  localparam logic [1:0] WBDATA_PCPLUS4 = 2'd2;

  localparam logic [0:0] MEMST_IDLE     = 1'b0;
  localparam logic [0:0] MEMST_WAIT     = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        rfwr;
    logic [4:0]  sel;
    logic [31:0] data;
  } wb_bundle_t;

  // Little-endian byte enables; any op other than byte/half is a word.
  function automatic logic [3:0] store_be(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      MEMOP_BYTE: store_be = 4'b0001 << lo;
      MEMOP_HALF: store_be = lo[1] ? 4'b1100 : 4'b0011;
      default:    store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the enables alone pick the target.
  function automatic logic [31:0] store_wdata(input logic [1:0] op, input logic [31:0] sd);
    case (op)
      MEMOP_BYTE: store_wdata = {4{sd[7:0]}};
      MEMOP_HALF: store_wdata = {2{sd[15:0]}};
      default:    store_wdata = sd;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] lo);
    case (op)
      MEMOP_BYTE: is_misaligned = 1'b0;
      MEMOP_HALF: is_misaligned = lo[0];
      default:    is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: extracts a byte/half/word from a little-endian memory word and
// zero- or sign-extends it to 32 bits.
//   rdata_i     : raw word from data memory
//   addr_lo_i   : byte offset of the access (half uses bit 1 only)
//   memop_i     : access size (MEMOP_*)
//   sign_ext_i  : 1 = sign-extend, 0 = zero-extend
//   load_data_o : aligned, extended load value
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  memop_i,
  input  logic        sign_ext_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    byte_s      = 8'd0;
    half_s      = 16'd0;
    load_data_o = rdata_i;
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    if (addr_lo_i[1]) begin
      half_s = rdata_i[31:16];
    end else begin
      half_s = rdata_i[15:0];
    end
    case (memop_i)
      MEMOP_BYTE: load_data_o = {{24{sign_ext_i & byte_s[7]}}, byte_s};
      MEMOP_HALF: load_data_o = {{16{sign_ext_i & half_s[15]}}, half_s};
      default:    load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Runs a req/ack transaction on the word-wide data memory for loads/stores,
// stalls upstream while it is outstanding, and registers the MEM/WB bundle.
// Ports:
//   clk, rst (sync, active-high)
//   EX/MEM  : in_valid, alu_result, store_data, pc_plus4, MEMWr, MEMOp,
//             loadSignExt, WBSel, RFWr, mux_WBData
//   hold    : mem_stall (combinational)
//   memory  : dmem_req/we/addr/be/wdata out, dmem_rdata/dmem_ack in
//   MEM/WB  : wb_valid, wb_rfwr, wb_sel, wb_data (registered)
//   except  : mem_excp, badvaddr (registered)
// Build option: MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses trap instead of being silently aligned down.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_plus4,
  input  logic        MEMWr,
  input  logic [1:0]  MEMOp,
  input  logic        loadSignExt,
  input  logic [4:0]  WBSel,
  input  logic        RFWr,
  input  logic [1:0]  mux_WBData,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_rfwr,
  output logic [4:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        mem_excp,
  output logic [31:0] badvaddr
);

  logic [0:0]  state_q, state_d;
  wb_bundle_t  wb_q, wb_d;
  logic        we_q, sext_q, load_q, rfwr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  memop_q, lo_q;
  logic [4:0]  sel_q;

  logic        mem_op_s, is_load_s, fault_s, accept_s;
  logic [31:0] load_data_s, direct_data_s;

  assign mem_op_s      = in_valid && (MEMWr || (mux_WBData == WBDATA_MEM));
  assign is_load_s     = (mux_WBData == WBDATA_MEM) && !MEMWr;
  assign direct_data_s = (mux_WBData == WBDATA_PCPLUS4) ? pc_plus4 : alu_result;

`ifdef MISALIGN_TRAP_EN
  assign fault_s = mem_op_s && is_misaligned(MEMOp, alu_result[1:0]);
`else
  assign fault_s = 1'b0;
`endif

  assign accept_s  = (state_q == MEMST_IDLE) && mem_op_s && !fault_s;
  // Stall drops in the ack cycle so upstream advances on the same edge.
  assign mem_stall = accept_s || ((state_q == MEMST_WAIT) && !dmem_ack);

  load_align u_load_align (
    .rdata_i     (dmem_rdata),
    .addr_lo_i   (lo_q),
    .memop_i     (memop_q),
    .sign_ext_i  (sext_q),
    .load_data_o (load_data_s)
  );

  // Next state and next MEM/WB contents; a bubble unless something retires.
  always_comb begin
    state_d = state_q;
    wb_d    = '{valid: 1'b0, rfwr: 1'b0, sel: 5'd0, data: 32'd0};
    case (state_q)
      MEMST_IDLE: begin
        if (accept_s) begin
          state_d = MEMST_WAIT;
        end else if (fault_s) begin
          wb_d = '{valid: 1'b1, rfwr: 1'b0, sel: WBSel, data: alu_result};
        end else begin
          wb_d = '{valid: in_valid, rfwr: RFWr && in_valid, sel: WBSel, data: direct_data_s};
        end
      end
      MEMST_WAIT: begin
        if (dmem_ack) begin
          state_d = MEMST_IDLE;
          wb_d    = '{valid: 1'b1, rfwr: load_q && rfwr_q, sel: sel_q,
                      data: load_q ? load_data_s : 32'd0};
        end else begin
          state_d = MEMST_WAIT;
        end
      end
      default: state_d = MEMST_IDLE;
    endcase
  end

  // State and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEMST_IDLE;
      wb_q    <= '{valid: 1'b0, rfwr: 1'b0, sel: 5'd0, data: 32'd0};
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  // Request fields latched at accept and held stable through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      memop_q <= 2'd0;
      lo_q    <= 2'd0;
      sext_q  <= 1'b0;
      load_q  <= 1'b0;
      rfwr_q  <= 1'b0;
      sel_q   <= 5'd0;
    end else if (accept_s) begin
      we_q    <= MEMWr;
      addr_q  <= {alu_result[31:2], 2'b00};
      be_q    <= store_be(MEMOp, alu_result[1:0]);
      wdata_q <= store_wdata(MEMOp, store_data);
      memop_q <= MEMOp;
      lo_q    <= alu_result[1:0];
      sext_q  <= loadSignExt;
      load_q  <= is_load_s;
      rfwr_q  <= RFWr && in_valid;
      sel_q   <= WBSel;
    end
  end

  assign dmem_req   = (state_q == MEMST_WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  assign wb_valid = wb_q.valid;
  assign wb_rfwr  = wb_q.rfwr;
  assign wb_sel   = wb_q.sel;
  assign wb_data  = wb_q.data;

`ifdef MISALIGN_TRAP_EN
  logic        excp_q;
  logic [31:0] badvaddr_q;

  // Fault report lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      excp_q     <= 1'b0;
      badvaddr_q <= 32'd0;
    end else begin
      excp_q     <= (state_q == MEMST_IDLE) && fault_s;
      badvaddr_q <= ((state_q == MEMST_IDLE) && fault_s) ? alu_result : 32'd0;
    end
  end

  assign mem_excp = excp_q;
  assign badvaddr = badvaddr_q;
`else
  assign mem_excp = 1'b0;
  assign badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage with a
// transaction-level reference model and a simple ack-delay memory responder.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk, rst;
  logic        in_valid, MEMWr, loadSignExt, RFWr;
  logic [31:0] alu_result, store_data, pc_plus4;
  logic [1:0]  MEMOp, mux_WBData;
  logic [4:0]  WBSel;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_rfwr, mem_excp;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data, badvaddr;

  int total = 0;
  int bad   = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .pc_plus4(pc_plus4), .MEMWr(MEMWr), .MEMOp(MEMOp),
    .loadSignExt(loadSignExt), .WBSel(WBSel), .RFWr(RFWr), .mux_WBData(mux_WBData),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
    .wb_rfwr(wb_rfwr), .wb_sel(wb_sel), .wb_data(wb_data),
    .mem_excp(mem_excp), .badvaddr(badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(input logic [1:0] op, input logic [31:0] a);
    int lane;
    lane = int'(a % 4);
    if (op == MEMOP_BYTE) return 4'(1 << lane);
    if (op == MEMOP_HALF) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] op, input logic [31:0] sd);
    if (op == MEMOP_BYTE) return (sd & 32'h000000FF) * 32'h01010101;
    if (op == MEMOP_HALF) return (sd & 32'h0000FFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] rd, input logic sx);
    int sh, w;
    logic [31:0] mask, v;
    if (op == MEMOP_BYTE) begin
      sh = 8 * int'(a % 4); w = 8;
    end else if (op == MEMOP_HALF) begin
      sh = 16 * int'((a / 2) % 2); w = 16;
    end else begin
      return rd;
    end
    mask = (32'd1 << w) - 32'd1;
    v = (rd >> sh) & mask;
    if (sx && v[w-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic m_fault(input logic [1:0] op, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (op == MEMOP_BYTE) return 1'b0;
    if (op == MEMOP_HALF) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one instruction at a negedge and follow it to retirement.
  task automatic do_op(input logic v, input logic wr, input logic [1:0] op, input logic sx,
                       input logic [1:0] src, input logic rf, input logic [4:0] sel,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                       input int nwait, input logic [31:0] rdata);
    logic memop, load, flt;
    int stalls;
    in_valid = v; MEMWr = wr; MEMOp = op; loadSignExt = sx; mux_WBData = src;
    RFWr = rf; WBSel = sel; alu_result = alu; store_data = sd; pc_plus4 = pc;
    dmem_ack = 1'($urandom_range(0, 1));  // ignored while idle
    dmem_rdata = $urandom;
    memop = v && (wr || src == WBDATA_MEM);
    load  = (src == WBDATA_MEM) && !wr;
    flt   = memop && m_fault(op, alu);
    #1;
    if (!memop || flt) begin
      check("stall_idle", 32'(mem_stall), 32'd0);
      @(negedge clk);
      check("req_idle", 32'(dmem_req), 32'd0);
      check("wb_valid_d", 32'(wb_valid), flt ? 32'd1 : 32'(v));
      check("wb_rfwr_d", 32'(wb_rfwr), flt ? 32'd0 : 32'(rf & v));
      check("wb_sel_d", 32'(wb_sel), 32'(sel));
      check("wb_data_d", wb_data, (flt || src != WBDATA_PCPLUS4) ? alu : pc);
      check("excp", 32'(mem_excp), 32'(flt));
      check("badvaddr", badvaddr, flt ? alu : 32'd0);
    end else begin
      check("stall_accept", 32'(mem_stall), 32'd1);
      stalls = 1;
      for (int w = 1; w <= nwait; w++) begin
        @(negedge clk);
        check("req_wait", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(wr));
        check("addr", dmem_addr, alu & 32'hFFFFFFFC);
        check("wb_bubble", 32'(wb_valid), 32'd0);
        if (!load) begin
          check("be", 32'(dmem_be), 32'(m_be(op, alu)));
          check("wdata", dmem_wdata, m_wdata(op, sd));
        end
        if (w == nwait) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        #1;
        if (w == nwait) begin
          check("stall_ack", 32'(mem_stall), 32'd0);
        end else begin
          check("stall_wait", 32'(mem_stall), 32'd1);
          stalls++;
        end
      end
      check("stall_cycles", 32'(stalls), 32'(nwait));
      @(negedge clk);
      dmem_ack = 1'b0;
      check("req_done", 32'(dmem_req), 32'd0);
      check("wb_valid_m", 32'(wb_valid), 32'd1);
      check("wb_rfwr_m", 32'(wb_rfwr), load ? 32'(rf) : 32'd0);
      check("wb_sel_m", 32'(wb_sel), 32'(sel));
      if (load) check("wb_load", wb_data, m_load(op, alu, rdata, sx));
    end
  endtask

  initial begin
    logic [1:0] rop, rsrc;
    logic rwr, rv;
    int k;
    rst = 1'b1; in_valid = 1'b0; MEMWr = 1'b0; MEMOp = 2'd0; loadSignExt = 1'b0;
    mux_WBData = 2'd0; RFWr = 1'b0; WBSel = 5'd0; alu_result = 32'd0;
    store_data = 32'd0; pc_plus4 = 32'd0; dmem_rdata = 32'd0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb", {wb_valid, wb_rfwr, 25'(wb_sel)}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_excp", {31'd0, mem_excp} | badvaddr, 32'd0);
    rst = 1'b0;

    // ADD
    do_op(1'b1, 1'b0, MEMOP_WORD, 1'b0, WBDATA_ALU, 1'b1, 5'd8, 32'h5, 32'h0, 32'h104, 1, 32'h0);
    // SB 0x1003, ack in fourth WAIT cycle
    do_op(1'b1, 1'b1, MEMOP_BYTE, 1'b0, WBDATA_ALU, 1'b0, 5'd0, 32'h1003, 32'hA5, 32'h108, 4, 32'h0);
    // LH / LHU / LB
    do_op(1'b1, 1'b0, MEMOP_HALF, 1'b1, WBDATA_MEM, 1'b1, 5'd3, 32'h2002, 32'h0, 32'h10C, 2, 32'h80011234);
    check("lh_const", wb_data, 32'hFFFF8001);
    do_op(1'b1, 1'b0, MEMOP_HALF, 1'b0, WBDATA_MEM, 1'b1, 5'd4, 32'h2002, 32'h0, 32'h110, 1, 32'h80011234);
    check("lhu_const", wb_data, 32'h00008001);
    do_op(1'b1, 1'b0, MEMOP_BYTE, 1'b1, WBDATA_MEM, 1'b1, 5'd5, 32'h2001, 32'h0, 32'h114, 1, 32'h00007F00);
    check("lb_const", wb_data, 32'h0000007F);
    // Back-to-back LW then SW, zero-wait ack
    do_op(1'b1, 1'b0, MEMOP_WORD, 1'b0, WBDATA_MEM, 1'b1, 5'd6, 32'h4000, 32'h0, 32'h118, 1, 32'hCAFEF00D);
    do_op(1'b1, 1'b1, MEMOP_WORD, 1'b0, WBDATA_ALU, 1'b0, 5'd0, 32'h4004, 32'h12345678, 32'h11C, 1, 32'h0);
    // Misaligned LW
    do_op(1'b1, 1'b0, MEMOP_WORD, 1'b0, WBDATA_MEM, 1'b1, 5'd7, 32'h3002, 32'h0, 32'h120, 1, 32'h89ABCDEF);

    // Reset in the second WAIT cycle
    in_valid = 1'b1; MEMWr = 1'b0; MEMOp = MEMOP_WORD; mux_WBData = WBDATA_MEM;
    RFWr = 1'b1; WBSel = 5'd9; alu_result = 32'h5000; dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rstw_req", 32'(dmem_req), 32'd0);
    check("rstw_wb", {wb_valid, wb_rfwr, 25'(wb_sel)}, 32'd0);
    check("rstw_wbdata", wb_data, 32'd0);
    check("rstw_stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;
    do_op(1'b1, 1'b0, MEMOP_BYTE, 1'b0, WBDATA_MEM, 1'b1, 5'd10, 32'h6003, 32'h0, 32'h124, 2, 32'hF1000000);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      rop = 2'($urandom_range(0, 2));
      rv = 1'b1;
      case (k)
        0: begin rwr = 1'b0; rsrc = ($urandom_range(0, 1) != 0) ? WBDATA_PCPLUS4 : WBDATA_ALU; end
        1: begin rv = 1'b0; rwr = 1'($urandom_range(0, 1)); rsrc = 2'($urandom_range(0, 2)); end
        2: begin rwr = 1'b0; rsrc = WBDATA_MEM; end
        default: begin rwr = 1'b1; rsrc = 2'($urandom_range(0, 2)); end
      endcase
      do_op(rv, rwr, rop, 1'($urandom_range(0, 1)), rsrc, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            $urandom_range(1, 4), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
